watermark_sequencer: RTL and testbench
======================================

WATERMARK_SEQUENCER -- requirements
Module: watermark_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles before a switch change is accepted.
REQ-002 Parameter TIMEOUT_CYCLES, default 16777216, maximum cycles from proc_start to proc_done.
REQ-003 clk  input  1  system clock; the block has one clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 image_choice  input  1  raw image-select switch, asynchronous.
REQ-006 water_choice  input  1  raw watermark-select switch, asynchronous.
REQ-007 vs  input  1  VGA vertical sync, active-low, clk domain.
REQ-008 proc_waiting  input  1  processor idle and ready for a job.
REQ-009 proc_done  input  1  processor finished the current job (level).
REQ-010 proc_start  output  1  one-cycle job start pulse.
REQ-011 proc_image_sel, proc_water_sel  output  1 each  job selection presented to the processor.
REQ-012 disp_image_sel, disp_water_sel  output  1 each  selection the display path shows.
REQ-013 busy  output  1  job in flight or display swap pending.
REQ-014 timeout_err  output  1  sticky job-timeout flag.

Function
REQ-015 image_choice and water_choice SHALL each pass through a 2-flop synchronizer before debounce.
REQ-016 Debounced value SHALL update only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion restarts the count.
REQ-017 FSM states SHALL be IDLE, START, ACK, RUN, SWAP, ERR.
REQ-018 IDLE -> START when proc_waiting=1 and (pending=1 or debounced pair != job pair); job pair latches debounced pair and pending clears on that transition.
REQ-019 START SHALL assert proc_start for exactly one cycle, then go to ACK.
REQ-020 ACK -> RUN on the first cycle proc_waiting=0.
REQ-021 RUN -> SWAP on the first cycle proc_done=1.
REQ-022 Timeout counter SHALL clear in START, increment each cycle in ACK and RUN, and on reaching TIMEOUT_CYCLES-1 go to ERR instead of advancing.
REQ-023 ERR SHALL set timeout_err=1 and hold; only rst_n leaves ERR; disp outputs are unchanged.
REQ-024 SWAP SHALL wait for a vs falling edge (registered vs 1, current vs 0); on that edge disp pair <= job pair and the FSM goes to IDLE.
REQ-025 A vs falling edge on the cycle SWAP is entered SHALL be counted.
REQ-026 Switch changes during START/ACK/RUN/SWAP SHALL not alter the job pair; they are picked up by the IDLE compare afterwards.
REQ-027 proc_done=1 in the same cycle the debounced value changes: RUN->SWAP proceeds with the old job; new job follows after SWAP.
REQ-028 busy SHALL be 1 in START, ACK, RUN and SWAP, 0 in IDLE and ERR.
REQ-029 proc_image_sel/proc_water_sel SHALL equal the job pair at all times.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, pending=1, job pair 00, disp pair 00, debounced pair 00, synchronizers 0, counters 0, proc_start 0, busy 0, timeout_err 0.
REQ-031 Reset mid-job SHALL abandon the job; after release one job with pair 00 SHALL run once proc_waiting=1.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64)
REQ-032 Release reset with switches 00, proc_waiting=1 -> proc_start one cycle pulse, busy=1; drop waiting, raise done, pulse vs low -> disp pair 00, busy=0.
REQ-033 Set image_choice=1 for 3 cycles then 0 -> no new job; hold 1 for 6+ cycles -> proc_start, proc pair 10; after done and vs edge disp pair 10.
REQ-034 Start job, never assert proc_done -> timeout_err=1 at 63 cycles after START, busy=0, disp pair unchanged, proc_start never pulses again until reset.
REQ-035 Toggle water_choice to 1 while in RUN -> proc pair unchanged until SWAP completes, then second job with pair 01 starts.
REQ-036 Assert rst_n=0 while in RUN with pair 11 -> all outputs 0 immediately; after release with switches 11 stable, job 00 runs first, then job 11.
REQ-037 Hold vs=1 throughout SWAP -> disp pair unchanged and busy=1 indefinitely; first vs falling edge commits disp pair.

Source files
------------

// File: rtl/watermark_sequencer.sv
`timescale 1ns/1ps
// Watermark job sequencer: debounces the image/watermark switches, hands one job
// at a time to the processor and commits the shown selection on a VGA vsync fall.
module watermark_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 16777216
) (
  input  logic clk,
  input  logic rst_n,
  input  logic image_choice,
  input  logic water_choice,
  input  logic vs,
  input  logic proc_waiting,
  input  logic proc_done,
  output logic proc_start,
  output logic proc_image_sel,
  output logic proc_water_sel,
  output logic disp_image_sel,
  output logic disp_water_sel,
  output logic busy,
  output logic timeout_err
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, ACK, RUN, SWAP, ERR} state_t;

  state_t state, state_next;

  // Bit 1 is the image switch, bit 0 the watermark switch, in every pair below.
  logic [1:0]         sync1, sync2, deb_pair;
  logic [1:0][DW-1:0] deb_cnt;
  logic [1:0]         job_pair, disp_pair;
  logic               pending;
  logic               vs_q;
  logic [TW-1:0]      tmo_cnt, tmo_next, tmo_inc;
  logic               load_job, load_disp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {image_choice, water_choice};
      sync2 <= sync1;
    end
  end

  // A switch value is accepted only after it has disagreed with the current
  // debounced value for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_pair <= '0;
      deb_cnt  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb_pair[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_pair[i] <= sync2[i];
          deb_cnt[i]  <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= 1'b1;
      job_pair  <= '0;
      disp_pair <= '0;
      tmo_cnt   <= '0;
      vs_q      <= 1'b1;
    end else begin
      state   <= state_next;
      tmo_cnt <= tmo_next;
      vs_q    <= vs;
      if (load_job) begin
        job_pair <= deb_pair;
        pending  <= 1'b0;
      end
      if (load_disp) begin
        disp_pair <= job_pair;
      end
    end
  end

  assign tmo_inc = tmo_cnt + 1'b1;

  // The timeout check takes priority over the normal ACK/RUN hand-off.
  always_comb begin
    state_next = state;
    tmo_next   = tmo_cnt;
    load_job   = 1'b0;
    load_disp  = 1'b0;
    case (state)
      IDLE: begin
        if (proc_waiting && (pending || (deb_pair != job_pair))) begin
          state_next = START;
          load_job   = 1'b1;
        end
      end
      START: begin
        tmo_next   = '0;
        state_next = ACK;
      end
      ACK: begin
        tmo_next = tmo_inc;
        if (tmo_inc == TMO_LIMIT) begin
          state_next = ERR;
        end else if (!proc_waiting) begin
          state_next = RUN;
        end
      end
      RUN: begin
        tmo_next = tmo_inc;
        if (tmo_inc == TMO_LIMIT) begin
          state_next = ERR;
        end else if (proc_done) begin
          state_next = SWAP;
        end
      end
      SWAP: begin
        if (vs_q && !vs) begin
          load_disp  = 1'b1;
          state_next = IDLE;
        end
      end
      ERR: begin
        state_next = ERR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign proc_start     = (state == START);
  assign busy           = (state == START) || (state == ACK) ||
                          (state == RUN)   || (state == SWAP);
  assign timeout_err    = (state == ERR);
  assign proc_image_sel = job_pair[1];
  assign proc_water_sel = job_pair[0];
  assign disp_image_sel = disp_pair[1];
  assign disp_water_sel = disp_pair[0];

endmodule

// File: tb/tb_watermark_sequencer.sv
`timescale 1ns/1ps
// Directed bench for watermark_sequencer with short debounce/timeout parameters;
// expected values are hand-derived cycle counts from the switch/handshake timing.
module tb_watermark_sequencer;

  localparam int DEB = 4;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic image_choice = 1'b0;
  logic water_choice = 1'b0;
  logic vs = 1'b1;
  logic proc_waiting = 1'b0;
  logic proc_done = 1'b0;
  logic proc_start, proc_image_sel, proc_water_sel;
  logic disp_image_sel, disp_water_sel, busy, timeout_err;

  int n_checks = 0;
  int n_fail = 0;
  int start_count = 0;
  int starts_before = 0;

  watermark_sequencer #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .image_choice(image_choice),
    .water_choice(water_choice),
    .vs(vs),
    .proc_waiting(proc_waiting),
    .proc_done(proc_done),
    .proc_start(proc_start),
    .proc_image_sel(proc_image_sel),
    .proc_water_sel(proc_water_sel),
    .disp_image_sel(disp_image_sel),
    .disp_water_sel(disp_water_sel),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (proc_start === 1'b1) start_count++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic img, input logic wat, input logic waiting,
                               input logic done, input logic vsync);
    image_choice = img;
    water_choice = wat;
    proc_waiting = waiting;
    proc_done    = done;
    vs           = vsync;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitStart(input string tag, input int budget);
    int i = 0;
    while (proc_start !== 1'b1 && i < budget) begin
      step(1);
      i++;
    end
    checkOutput(tag, 32'(proc_start), 32'd1);
  endtask

  // Called in the START cycle: drop waiting, finish, then a vsync fall on SWAP entry.
  task automatic finishJob();
    proc_waiting = 1'b0;
    step(2);
    proc_done = 1'b1;
    step(1);
    proc_done = 1'b0;
    vs = 1'b0;
    step(1);
    vs = 1'b1;
    proc_waiting = 1'b1;
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    checkOutput("rst_proc_start", 32'(proc_start), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'd0);
    checkOutput("rst_proc_pair", 32'({proc_image_sel, proc_water_sel}), 32'd0);
    checkOutput("rst_disp_pair", 32'({disp_image_sel, disp_water_sel}), 32'd0);
    step(3);

    $display("[TB] first job after reset, pair 00");
    proc_waiting = 1'b1;
    rst_n = 1'b1;
    step(1);
    checkOutput("t1_start", 32'(proc_start), 32'd1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_proc_pair", 32'({proc_image_sel, proc_water_sel}), 32'd0);
    step(1);
    checkOutput("t1_pulse_width", 32'(proc_start), 32'd0);
    checkOutput("t1_busy_ack", 32'(busy), 32'd1);
    proc_waiting = 1'b0;
    step(2);
    proc_done = 1'b1;
    step(1);
    proc_done = 1'b0;
    step(10);
    checkOutput("t1_swap_hold_busy", 32'(busy), 32'd1);
    vs = 1'b0;
    step(1);
    vs = 1'b1;
    checkOutput("t1_swap_done_busy", 32'(busy), 32'd0);
    checkOutput("t1_disp_pair", 32'({disp_image_sel, disp_water_sel}), 32'd0);
    proc_waiting = 1'b1;
    starts_before = start_count;
    step(5);
    checkOutput("t1_no_restart", 32'(start_count), 32'(starts_before));

    $display("[TB] image switch glitch then stable change");
    image_choice = 1'b1;
    step(3);
    image_choice = 1'b0;
    step(12);
    checkOutput("t2_glitch_no_start", 32'(start_count), 32'(starts_before));
    checkOutput("t2_glitch_busy", 32'(busy), 32'd0);
    image_choice = 1'b1;
    step(6);
    checkOutput("t2_not_yet", 32'(proc_start), 32'd0);
    step(1);
    checkOutput("t2_start", 32'(proc_start), 32'd1);
    checkOutput("t2_proc_pair", 32'({proc_image_sel, proc_water_sel}), 32'd2);
    checkOutput("t2_disp_old", 32'({disp_image_sel, disp_water_sel}), 32'd0);
    finishJob();
    checkOutput("t2_disp_pair", 32'({disp_image_sel, disp_water_sel}), 32'd2);
    checkOutput("t2_idle_busy", 32'(busy), 32'd0);

    $display("[TB] watermark switch change while running");
    image_choice = 1'b0;
    waitStart("t3_start_00", 12);
    checkOutput("t3_proc_pair_00", 32'({proc_image_sel, proc_water_sel}), 32'd0);
    proc_waiting = 1'b0;
    step(2);
    water_choice = 1'b1;
    starts_before = start_count;
    step(10);
    checkOutput("t3_pair_held", 32'({proc_image_sel, proc_water_sel}), 32'd0);
    checkOutput("t3_no_new_start", 32'(start_count), 32'(starts_before));
    checkOutput("t3_busy_run", 32'(busy), 32'd1);
    proc_done = 1'b1;
    step(1);
    proc_done = 1'b0;
    vs = 1'b0;
    step(1);
    vs = 1'b1;
    checkOutput("t3_disp_00", 32'({disp_image_sel, disp_water_sel}), 32'd0);
    proc_waiting = 1'b1;
    step(1);
    checkOutput("t3_second_start", 32'(proc_start), 32'd1);
    checkOutput("t3_proc_pair_01", 32'({proc_image_sel, proc_water_sel}), 32'd1);
    finishJob();
    checkOutput("t3_disp_01", 32'({disp_image_sel, disp_water_sel}), 32'd1);

    $display("[TB] reset in the middle of a job with pair 11");
    image_choice = 1'b1;
    waitStart("t4_start_11", 12);
    checkOutput("t4_proc_pair_11", 32'({proc_image_sel, proc_water_sel}), 32'd3);
    proc_waiting = 1'b0;
    step(2);
    checkOutput("t4_busy_run", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t4_rst_proc_start", 32'(proc_start), 32'd0);
    checkOutput("t4_rst_busy", 32'(busy), 32'd0);
    checkOutput("t4_rst_proc_pair", 32'({proc_image_sel, proc_water_sel}), 32'd0);
    checkOutput("t4_rst_disp_pair", 32'({disp_image_sel, disp_water_sel}), 32'd0);
    checkOutput("t4_rst_timeout", 32'(timeout_err), 32'd0);
    step(2);
    proc_waiting = 1'b1;
    rst_n = 1'b1;
    step(1);
    checkOutput("t4_pending_job", 32'(proc_start), 32'd1);
    checkOutput("t4_pending_pair", 32'({proc_image_sel, proc_water_sel}), 32'd0);
    finishJob();
    checkOutput("t4_disp_00", 32'({disp_image_sel, disp_water_sel}), 32'd0);
    waitStart("t4_job_11", 20);
    checkOutput("t4_job_pair_11", 32'({proc_image_sel, proc_water_sel}), 32'd3);
    finishJob();
    checkOutput("t4_disp_11", 32'({disp_image_sel, disp_water_sel}), 32'd3);

    $display("[TB] job that never completes");
    image_choice = 1'b0;
    water_choice = 1'b0;
    waitStart("t5_start", 12);
    checkOutput("t5_proc_pair", 32'({proc_image_sel, proc_water_sel}), 32'd0);
    proc_waiting = 1'b0;
    step(TMO - 1);
    checkOutput("t5_before_timeout", 32'(timeout_err), 32'd0);
    checkOutput("t5_busy_before", 32'(busy), 32'd1);
    step(1);
    checkOutput("t5_timeout", 32'(timeout_err), 32'd1);
    checkOutput("t5_busy_err", 32'(busy), 32'd0);
    checkOutput("t5_disp_kept", 32'({disp_image_sel, disp_water_sel}), 32'd3);
    proc_waiting = 1'b1;
    image_choice = 1'b1;
    starts_before = start_count;
    step(15);
    checkOutput("t5_no_start_in_err", 32'(start_count), 32'(starts_before));
    checkOutput("t5_timeout_sticky", 32'(timeout_err), 32'd1);

    $display("[TB] reset leaves the error state");
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_timeout", 32'(timeout_err), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    checkOutput("t6_start_after_err", 32'(proc_start), 32'd1);
    checkOutput("t6_pair_00", 32'({proc_image_sel, proc_water_sel}), 32'd0);
    finishJob();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
